// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: ALU op codes, the highest legal op
// code and the sequencer FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;

  localparam logic [3:0] OP_MAX = OP_DEC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Requester and ALU-side signals of the ALU sequencer. The slave modport is the
// sequencer; the master modport is its environment (both requesters plus the ALU).
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req_0, req_1;
  logic [3:0]       op_0, op_1;
  logic [WIDTH-1:0] a_0, b_0, a_1, b_1;
  logic             done_0, done_1, err_0, err_1;
  logic [WIDTH-1:0] res_data;
  logic             res_carry, res_zero, busy;
  logic [WIDTH-1:0] alu_in_1, alu_in_2;
  logic [3:0]       alu_select;
  logic             alu_enable, alu_carry_in;
  logic [WIDTH-1:0] alu_data;
  logic             alu_carry_out, alu_zero;

  modport slave (
    input  req_0, op_0, a_0, b_0, req_1, op_1, a_1, b_1,
    input  alu_data, alu_carry_out, alu_zero,
    output done_0, done_1, err_0, err_1,
    output res_data, res_carry, res_zero, busy,
    output alu_in_1, alu_in_2, alu_select, alu_enable, alu_carry_in
  );

  modport master (
    output req_0, op_0, a_0, b_0, req_1, op_1, a_1, b_1,
    output alu_data, alu_carry_out, alu_zero,
    input  done_0, done_1, err_0, err_1,
    input  res_data, res_carry, res_zero, busy,
    input  alu_in_1, alu_in_2, alu_select, alu_enable, alu_carry_in
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win last is
// granted; last_grant only advances when the owner accepts the grant via update.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       valid,
  output logic       grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    valid = |req;
    if (req[0] && req[1]) begin
      grant = ~last_grant_q;
    end else begin
      grant = req[1];
    end
    last_grant_d = (update && valid) ? grant : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one bus-driving ALU between two requesters: arbitrate, drive the ALU for
// exactly one cycle, capture result/flags, pulse done. Option: ALU_CARRY_CHAIN_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int         WIDTH  = 16,
  parameter logic [3:0] OP_MAX = alu_pkg::OP_MAX
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_in_1_q, alu_in_1_d;
  logic [WIDTH-1:0] alu_in_2_q, alu_in_2_d;
  logic [3:0]       alu_select_q, alu_select_d;
  logic             alu_enable_q, alu_enable_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic             res_zero_q, res_zero_d;
  logic             busy_q, busy_d;

  logic             arb_valid, arb_grant, arb_update;
  logic [3:0]       win_op;
  logic [WIDTH-1:0] win_a, win_b;
  logic             win_legal;
  logic             start_op;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({bus.req_1, bus.req_0}),
    .update (arb_update),
    .valid  (arb_valid),
    .grant  (arb_grant)
  );

  always_comb begin
    win_op    = arb_grant ? bus.op_1 : bus.op_0;
    win_a     = arb_grant ? bus.a_1  : bus.a_0;
    win_b     = arb_grant ? bus.b_1  : bus.b_0;
    win_legal = (win_op <= OP_MAX);
    start_op  = (state_q == ST_IDLE) && arb_valid && win_legal;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    alu_in_1_d   = alu_in_1_q;
    alu_in_2_d   = alu_in_2_q;
    alu_select_d = alu_select_q;
    alu_enable_d = 1'b0;
    done_d       = 2'b00;
    err_d        = 2'b00;
    res_data_d   = res_data_q;
    res_carry_d  = res_carry_q;
    res_zero_d   = res_zero_q;
    arb_update   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          if (win_legal) begin
            alu_in_1_d   = win_a;
            alu_in_2_d   = win_b;
            alu_select_d = win_op;
            alu_enable_d = 1'b1;
            owner_d      = arb_grant;
            state_d      = ST_DRIVE;
          end else begin
            err_d[arb_grant] = 1'b1;
          end
        end
      end
      // ALU outputs are only valid while enable is high, i.e. at this edge.
      ST_DRIVE: begin
        res_data_d       = bus.alu_data;
        res_carry_d      = bus.alu_carry_out;
        res_zero_d       = bus.alu_zero;
        done_d[owner_q]  = 1'b1;
        state_d          = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      alu_in_1_q   <= '0;
      alu_in_2_q   <= '0;
      alu_select_q <= 4'd0;
      alu_enable_q <= 1'b0;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      res_data_q   <= '0;
      res_carry_q  <= 1'b0;
      res_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      alu_in_1_q   <= alu_in_1_d;
      alu_in_2_q   <= alu_in_2_d;
      alu_select_q <= alu_select_d;
      alu_enable_q <= alu_enable_d;
      done_q       <= done_d;
      err_q        <= err_d;
      res_data_q   <= res_data_d;
      res_carry_q  <= res_carry_d;
      res_zero_q   <= res_zero_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ALU_CARRY_CHAIN_EN
  // Per-requester carry so each requester can chain multi-word adds independently.
  logic [1:0] cf_q, cf_d;
  logic       alu_carry_in_q, alu_carry_in_d;

  always_comb begin
    cf_d           = cf_q;
    alu_carry_in_d = alu_carry_in_q;
    if (state_q == ST_DRIVE) begin
      cf_d[owner_q]  = bus.alu_carry_out;
      alu_carry_in_d = 1'b0;
    end else if (start_op) begin
      alu_carry_in_d = (win_op == OP_ADD) ? cf_q[arb_grant] : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cf_q           <= 2'b00;
      alu_carry_in_q <= 1'b0;
    end else begin
      cf_q           <= cf_d;
      alu_carry_in_q <= alu_carry_in_d;
    end
  end

  assign bus.alu_carry_in = alu_carry_in_q;
`else
  assign bus.alu_carry_in = 1'b0;
`endif

  assign bus.alu_in_1   = alu_in_1_q;
  assign bus.alu_in_2   = alu_in_2_q;
  assign bus.alu_select = alu_select_q;
  assign bus.alu_enable = alu_enable_q;
  assign bus.done_0     = done_q[0];
  assign bus.done_1     = done_q[1];
  assign bus.err_0      = err_q[0];
  assign bus.err_1      = err_q[1];
  assign bus.res_data   = res_data_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.res_zero   = res_zero_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios with literal expectations, then
// random two-requester traffic compared every cycle against a transaction model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_sequencer_if #(.WIDTH(W)) bus ();

  alu_sequencer #(.WIDTH(W), .OP_MAX(4'd7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference ALU behaviour: {carry, zero, data}
  function automatic logic [17:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    logic [16:0] w;
    w = '0;
    case (op)
      OP_ADD: w = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      OP_SUB: w = {1'b0, a} - {1'b0, b};
      OP_AND: w = {1'b0, a & b};
      OP_OR:  w = {1'b0, a | b};
      OP_XOR: w = {1'b0, a ^ b};
      OP_NOT: w = {1'b0, ~a};
      OP_INC: w = {1'b0, a} + 17'd1;
      OP_DEC: w = {1'b0, a} - 17'd1;
      default: w = '0;
    endcase
    return {w[16], (w[15:0] == 16'd0), w[15:0]};
  endfunction

  // ALU: outputs garbage whenever it is not enabled
  logic [17:0] alu_out;
  always_comb begin
    alu_out = {1'b1, 1'b1, 16'hDEAD};
    if (bus.alu_enable)
      alu_out = alu_ref(bus.alu_select, bus.alu_in_1, bus.alu_in_2, bus.alu_carry_in);
  end
  assign bus.alu_data      = alu_out[15:0];
  assign bus.alu_zero      = alu_out[16];
  assign bus.alu_carry_out = alu_out[17];

  // ---------------- transaction-level model ----------------
  logic        exp_enable = 0, exp_cin = 0, exp_busy = 0;
  logic [15:0] exp_in1 = 0, exp_in2 = 0, exp_res = 0;
  logic [3:0]  exp_sel = 0;
  logic [1:0]  exp_done = 0, exp_err = 0;
  logic        exp_carry = 0, exp_zero = 0;
  logic        m_last = 1'b1, m_owner = 1'b0;
  logic [1:0]  m_cf = 2'b00;
  int          m_hold = 0;  // edges left before the sequencer accepts a new request

  task automatic model_step();
    logic        w;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [17:0] r;
    if (reset) begin
      exp_enable = 0; exp_cin = 0; exp_busy = 0; exp_in1 = 0; exp_in2 = 0;
      exp_sel = 0; exp_done = 0; exp_err = 0; exp_res = 0; exp_carry = 0; exp_zero = 0;
      m_last = 1'b1; m_hold = 0; m_cf = 2'b00;
    end else begin
      exp_done = 0;
      exp_err  = 0;
      if (m_hold == 2) begin
        r = alu_ref(exp_sel, exp_in1, exp_in2, exp_cin);
        exp_res = r[15:0]; exp_zero = r[16]; exp_carry = r[17];
        m_cf[m_owner] = r[17];
        exp_done[m_owner] = 1'b1;
        exp_enable = 0; exp_cin = 0;
        m_hold = 1;
      end else if (m_hold == 1) begin
        exp_busy = 0;
        m_hold = 0;
      end else if (bus.req_0 || bus.req_1) begin
        w  = (bus.req_0 && bus.req_1) ? ~m_last : bus.req_1;
        op = w ? bus.op_1 : bus.op_0;
        a  = w ? bus.a_1  : bus.a_0;
        b  = w ? bus.b_1  : bus.b_0;
        m_last = w;
        if (op > OP_MAX) begin
          exp_err[w] = 1'b1;
        end else begin
          exp_in1 = a; exp_in2 = b; exp_sel = op;
`ifdef ALU_CARRY_CHAIN_EN
          exp_cin = (op == OP_ADD) ? m_cf[w] : 1'b0;
`else
          exp_cin = 1'b0;
`endif
          exp_enable = 1; exp_busy = 1; m_owner = w; m_hold = 2;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("alu_enable",   bus.alu_enable,   exp_enable);
      chk("alu_in_1",     bus.alu_in_1,     exp_in1);
      chk("alu_in_2",     bus.alu_in_2,     exp_in2);
      chk("alu_select",   bus.alu_select,   exp_sel);
      chk("alu_carry_in", bus.alu_carry_in, exp_cin);
      chk("done_0",       bus.done_0,       exp_done[0]);
      chk("done_1",       bus.done_1,       exp_done[1]);
      chk("err_0",        bus.err_0,        exp_err[0]);
      chk("err_1",        bus.err_1,        exp_err[1]);
      chk("res_data",     bus.res_data,     exp_res);
      chk("res_carry",    bus.res_carry,    exp_carry);
      chk("res_zero",     bus.res_zero,     exp_zero);
      chk("busy",         bus.busy,         exp_busy);
    end
  end

  // ---------------- directed helpers ----------------
  int          ev_done [2];
  int          ev_err  [2];
  int          en_cnt;
  logic [15:0] got_res [2];
  logic        got_c   [2];
  logic        got_z   [2];

  task automatic raise(input int r, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (r == 0) begin
      bus.req_0 = 1'b1; bus.op_0 = op; bus.a_0 = a; bus.b_0 = b;
    end else begin
      bus.req_1 = 1'b1; bus.op_1 = op; bus.a_1 = a; bus.b_1 = b;
    end
  endtask

  // Run until every raised request has completed; ends one idle negedge later.
  task automatic service(input int max_cyc, input bit mutate);
    ev_done[0] = -1; ev_done[1] = -1; ev_err[0] = -1; ev_err[1] = -1; en_cnt = 0;
    for (int n = 1; n <= max_cyc && (bus.req_0 || bus.req_1); n++) begin
      @(negedge clk);
      if (mutate && n == 1) begin
        bus.a_0 = 16'hFFFF; bus.b_0 = 16'h1111; bus.op_0 = OP_XOR;
      end
      if (bus.alu_enable) en_cnt++;
      if (bus.done_0) begin
        ev_done[0] = n; got_res[0] = bus.res_data; got_c[0] = bus.res_carry; got_z[0] = bus.res_zero;
        bus.req_0 = 1'b0;
      end
      if (bus.done_1) begin
        ev_done[1] = n; got_res[1] = bus.res_data; got_c[1] = bus.res_carry; got_z[1] = bus.res_zero;
        bus.req_1 = 1'b0;
      end
      if (bus.err_0) begin ev_err[0] = n; bus.req_0 = 1'b0; end
      if (bus.err_1) begin ev_err[1] = n; bus.req_1 = 1'b0; end
    end
    chk("service_timeout", {30'd0, bus.req_1, bus.req_0}, 32'd0);
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive_rand(input int r);
    logic req, dn, er;
    logic [3:0] op;
    req = (r == 0) ? bus.req_0 : bus.req_1;
    dn  = (r == 0) ? bus.done_0 : bus.done_1;
    er  = (r == 0) ? bus.err_0 : bus.err_1;
    if (req) begin
      if (dn || er) begin
        if (r == 0) bus.req_0 = 1'b0; else bus.req_1 = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        if (r == 0) begin bus.a_0 = pick_operand(); bus.b_0 = pick_operand(); end
        else        begin bus.a_1 = pick_operand(); bus.b_1 = pick_operand(); end
      end
    end else if ($urandom_range(0, 2) == 0) begin
      op = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      raise(r, op, pick_operand(), pick_operand());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.req_0 = 0; bus.op_0 = 0; bus.a_0 = 0; bus.b_0 = 0;
    bus.req_1 = 0; bus.op_1 = 0; bus.a_1 = 0; bus.b_1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_enable", bus.alu_enable, 32'd0);
    chk("rst_in_1",   bus.alu_in_1,   32'd0);
    chk("rst_in_2",   bus.alu_in_2,   32'd0);
    chk("rst_select", bus.alu_select, 32'd0);
    chk("rst_cin",    bus.alu_carry_in, 32'd0);
    chk("rst_pulses", {bus.done_0, bus.done_1, bus.err_0, bus.err_1}, 32'd0);
    chk("rst_res",    {bus.res_carry, bus.res_zero, bus.res_data}, 32'd0);
    chk("rst_busy",   bus.busy, 32'd0);
    reset = 1'b0;

    // Single op 3+4
    raise(0, OP_ADD, 16'h0003, 16'h0004);
    service(10, 1'b0);
    chk("single_latency", ev_done[0], 32'd2);
    chk("single_res",     got_res[0], 32'h0007);
    chk("single_flags",   {got_c[0], got_z[0]}, 32'd0);
    chk("single_enable_cycles", en_cnt, 32'd1);

    // Operands change right after grant
    raise(0, OP_ADD, 16'h0100, 16'h0020);
    service(10, 1'b1);
    chk("stable_res", got_res[0], 32'h0120);

    // Illegal op on requester 1
    raise(1, 4'hA, 16'h0001, 16'h0002);
    service(10, 1'b0);
    chk("illegal_err_cycle", ev_err[1], 32'd1);
    chk("illegal_no_done",   ev_done[1], 32'hFFFF_FFFF);
    chk("illegal_no_enable", en_cnt, 32'd0);
    chk("illegal_err_pulse", bus.err_1, 32'd0);
    chk("illegal_res_kept",  bus.res_data, 32'h0120);

    // Reset during DRIVE
    raise(0, OP_SUB, 16'h0010, 16'h0001);
    @(negedge clk);
    chk("rmid_enable_before", bus.alu_enable, 32'd1);
    #1 reset = 1'b1;
    bus.req_0 = 1'b0;
    #1;
    chk("rmid_enable",  bus.alu_enable, 32'd0);
    chk("rmid_busy",    bus.busy, 32'd0);
    chk("rmid_res",     {bus.res_carry, bus.res_zero, bus.res_data}, 32'd0);
    chk("rmid_in",      {bus.alu_in_1, bus.alu_select}, 32'd0);
    @(posedge clk);
    #1 chk("rmid_no_done", bus.done_0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Contention: requester 0 first, then INC 0xFFFF on requester 1
    raise(0, OP_ADD, 16'h1234, 16'h0001);
    raise(1, OP_INC, 16'hFFFF, 16'h0000);
    service(20, 1'b0);
    chk("cont_r0_latency", ev_done[0], 32'd2);
    chk("cont_r1_latency", ev_done[1], 32'd5);
    chk("cont_r0_res",     got_res[0], 32'h1235);
    chk("cont_r1_res",     got_res[1], 32'h0000);
    chk("cont_r1_flags",   {got_c[1], got_z[1]}, 32'd3);

    // Next tie goes to requester 0 again; these also clear both carries
    raise(0, OP_AND, 16'h00FF, 16'h0F0F);
    raise(1, OP_OR,  16'h0000, 16'h0000);
    service(20, 1'b0);
    chk("tie2_r0_first", ev_done[0], 32'd2);
    chk("tie2_r1_second", ev_done[1], 32'd5);
    chk("tie2_r0_res",   got_res[0], 32'h000F);
    chk("tie2_r1_zero",  {got_res[1], got_z[1]}, 32'h1);

    // Carry chain on requester 0 with an interleaved requester 1 add
    raise(0, OP_ADD, 16'hFFFF, 16'h0001);
    service(10, 1'b0);
    chk("chain_lo_res",   got_res[0], 32'h0000);
    chk("chain_lo_flags", {got_c[0], got_z[0]}, 32'd3);
    raise(1, OP_ADD, 16'h0010, 16'h0020);
    service(10, 1'b0);
    chk("chain_r1_res",   got_res[1], 32'h0030);
    raise(0, OP_ADD, 16'h0000, 16'h0000);
    service(10, 1'b0);
`ifdef ALU_CARRY_CHAIN_EN
    chk("chain_hi_res",   got_res[0], 32'h0001);
    chk("chain_hi_zero",  got_z[0], 32'd0);
`else
    chk("chain_hi_res",   got_res[0], 32'h0000);
    chk("chain_hi_zero",  got_z[0], 32'd1);
`endif

    // Random traffic with one asynchronous reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) begin
        #1 reset = 1'b1;
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        drive_rand(0);
        drive_rand(1);
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
